l1_dcache: RTL

- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits directly downstream of the CPU datapath MEM stage: it is the responder on the dmem_* bus.
- Fills and evicts whole 256-bit lines over a single-line physical-memory port (pmem_*).
- Hits complete with zero wait states, so the datapath's no_mem gating sees mem_resp in the same cycle as the request.

---
 rtl/l1_dcache_pkg.sv | 24 ++
 rtl/l1_dcache_if.sv | 35 +++
 rtl/l1_dcache_array.sv | 39 +++
 rtl/l1_dcache.sv | 133 +++++++++++++
 4 files changed

// File: rtl/l1_dcache_pkg.sv
// rtl/l1_dcache_pkg.sv - shared types, line geometry and byte-merge helper for the L1 data cache
package l1_cache_types;

    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/l1_dcache_if.sv
// rtl/l1_dcache_if.sv - CPU-side dmem bus and line-wide pmem bus of the L1 data cache
interface l1_dcache_if;
    import l1_cache_types::*;

    logic                 mem_read;
    logic                 mem_write;
    logic [31:0]          mem_address;
    logic [3:0]           mem_byte_enable;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;
    logic                 mem_resp;

    logic                 pmem_read;
    logic                 pmem_write;
    logic [31:0]          pmem_address;
    logic [LINE_BITS-1:0] pmem_wdata;
    logic [LINE_BITS-1:0] pmem_rdata;
    logic                 pmem_resp;

    // The cache is the slave on the dmem side and drives the pmem side.
    modport slave (
        input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/l1_dcache_array.sv
// rtl/l1_dcache_array.sv - flop array with asynchronous read, synchronous write and optional reset clear
module l1_dcache_array #(
    parameter int WIDTH       = 1,
    parameter int DEPTH       = 8,
    parameter bit RESET_CLEAR = 1'b0,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    generate
        if (RESET_CLEAR) begin : g_clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                end else if (we) begin
                    mem[addr] <= wdata;
                end
            end
        end else begin : g_noclear
            logic unused_rst;
            assign unused_rst = rst_n;

            always_ff @(posedge clk) begin
                if (we) mem[addr] <= wdata;
            end
        end
    endgenerate

endmodule

// File: rtl/l1_dcache.sv
// rtl/l1_dcache.sv - direct-mapped write-back write-allocate L1 data cache; L1_DCACHE_PERF_EN adds hit/miss counters
module l1_dcache
    import l1_cache_types::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    l1_dcache_if.slave  bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int SETS  = 2 ** S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    state_t state_q, state_d;

    logic [TAG_W-1:0]     tag;
    logic [S_INDEX-1:0]   index;
    logic [2:0]           word;
    logic                 unused_addr_bits;

    logic [LINE_BITS-1:0] line_r, line_w, merged_line;
    logic [TAG_W-1:0]     tag_r;
    logic                 valid_r, dirty_r;
    logic                 data_we, tag_we, valid_we, dirty_we;
    logic                 valid_wd, dirty_wd;
    logic                 req, hit;

    assign tag   = bus.mem_address[31:OFFSET_BITS+S_INDEX];
    assign index = bus.mem_address[OFFSET_BITS+S_INDEX-1:OFFSET_BITS];
    assign word  = bus.mem_address[OFFSET_BITS-1:2];
    assign unused_addr_bits = ^bus.mem_address[1:0];

    l1_dcache_array #(.WIDTH(LINE_BITS), .DEPTH(SETS), .RESET_CLEAR(1'b0)) u_data (
        .clk(clk), .rst_n(rst_n), .addr(index), .we(data_we), .wdata(line_w), .rdata(line_r)
    );
    l1_dcache_array #(.WIDTH(TAG_W), .DEPTH(SETS), .RESET_CLEAR(1'b0)) u_tag (
        .clk(clk), .rst_n(rst_n), .addr(index), .we(tag_we), .wdata(tag), .rdata(tag_r)
    );
    l1_dcache_array #(.WIDTH(1), .DEPTH(SETS), .RESET_CLEAR(1'b1)) u_valid (
        .clk(clk), .rst_n(rst_n), .addr(index), .we(valid_we), .wdata(valid_wd), .rdata(valid_r)
    );
    l1_dcache_array #(.WIDTH(1), .DEPTH(SETS), .RESET_CLEAR(1'b1)) u_dirty (
        .clk(clk), .rst_n(rst_n), .addr(index), .we(dirty_we), .wdata(dirty_wd), .rdata(dirty_r)
    );

    assign req = bus.mem_read | bus.mem_write;
    assign hit = valid_r & (tag_r == tag) & req & (state_q == IDLE);

    always_comb begin
        merged_line = line_r;
        merged_line[{word, 5'b0} +: 32] =
            be_merge(line_r[{word, 5'b0} +: 32], bus.mem_wdata, bus.mem_byte_enable);
    end

    assign bus.mem_rdata  = bus.mem_resp ? line_r[{word, 5'b0} +: 32] : 32'd0;
    assign bus.pmem_wdata = (state_q == WRITEBACK) ? line_r : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        bus.mem_resp     = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = 32'd0;
        data_we          = 1'b0;
        line_w           = merged_line;
        tag_we           = 1'b0;
        valid_we         = 1'b0;
        valid_wd         = 1'b0;
        dirty_we         = 1'b0;
        dirty_wd         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    bus.mem_resp = 1'b1;
                    // Simultaneous read+write is a store; empty byte enables still mark the line dirty.
                    if (bus.mem_write) begin
                        data_we  = 1'b1;
                        dirty_we = 1'b1;
                        dirty_wd = 1'b1;
                    end
                end else if (req) begin
                    state_d = (valid_r && dirty_r) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_r, index, 5'b0};
                if (bus.pmem_resp) begin
                    dirty_we = 1'b1;
                    state_d  = FILL;
                end
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {tag, index, 5'b0};
                if (bus.pmem_resp) begin
                    data_we  = 1'b1;
                    line_w   = bus.pmem_rdata;
                    tag_we   = 1'b1;
                    valid_we = 1'b1;
                    valid_wd = 1'b1;
                    dirty_we = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef L1_DCACHE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (bus.mem_resp) hit_count <= hit_count + 32'd1;
            if (state_q == IDLE && state_d != IDLE) miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule
